// File: rtl/mesh_terminal_if.sv
`default_nettype none
// ============================================================================
//  Module   : mesh_terminal_if
//  Purpose  : Terminal adapter between a host and a mesh router port.
//             TX side: host packets are queued with the next-hop byte
//             cleared, and offered to the router head-first.
//             RX side: a three-state handshake (IDLE/POP/CAP) pulls packets
//             from the router into an RX queue for the host. Captured
//             packets that carry a foreign destination are still queued,
//             and they are also counted as misroutes.
//  Ports    : clk, rst (sync, active-low)
//             host TX   : tx_push, tx_data, tx_full
//             router TX : data_out_i_in, pndng_i_in, popin
//             router RX : data_out, pndng, pop
//             host RX   : rx_pop, rx_data, rx_valid
//             stats     : tx_cnt, rx_cnt, misroute (16-bit, wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module mesh_terminal_if #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int id_r       = 0,
  parameter int id_c       = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tx_push,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  input  logic [pckg_sz-1:0] data_out,
  input  logic               pndng,
  output logic               pop,
  input  logic               rx_pop,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  output logic [15:0]        tx_cnt,
  output logic [15:0]        rx_cnt,
  output logic [15:0]        misroute
);

  localparam int               c_AW       = $clog2(fifo_depth);
  localparam logic [c_AW:0]    c_DEPTH    = (c_AW+1)'(fifo_depth);
  localparam logic [c_AW:0]    c_ONE      = (c_AW+1)'(1);
  localparam logic [pckg_sz-1:0] c_HOP_MASK = {8'h00, {(pckg_sz-8){1'b1}}};
  localparam logic [3:0]       c_ID_R     = 4'(id_r);
  localparam logic [3:0]       c_ID_C     = 4'(id_c);

  // --------------------------------------------------------------------------
  // TX queue
  // --------------------------------------------------------------------------
  logic [pckg_sz-1:0] r_tx_mem [fifo_depth];
  logic [c_AW-1:0]    r_tx_wp;
  logic [c_AW-1:0]    r_tx_rp;
  logic [c_AW:0]      r_tx_occ;
  logic [15:0]        r_tx_cnt;
  logic               w_tx_full;
  logic               w_tx_deq;
  logic               w_tx_enq;

  assign w_tx_full = (r_tx_occ == c_DEPTH);
  assign w_tx_deq  = popin && (r_tx_occ != '0);
  // A push against a full queue still lands if the same edge frees a slot.
  assign w_tx_enq  = tx_push && (!w_tx_full || w_tx_deq);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_occ <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_enq) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_deq) begin
        r_tx_rp  <= r_tx_rp + 1'b1;
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
      case ({w_tx_enq, w_tx_deq})
        2'b10:   r_tx_occ <= r_tx_occ + c_ONE;
        2'b01:   r_tx_occ <= r_tx_occ - c_ONE;
        default: r_tx_occ <= r_tx_occ;
      endcase
    end
  end

  // Storage is not reset; the next-hop byte is cleared on the way in.
  always_ff @(posedge clk) begin
    if (rst && w_tx_enq) r_tx_mem[r_tx_wp] <= tx_data & c_HOP_MASK;
  end

  assign tx_full       = w_tx_full;
  assign pndng_i_in    = (r_tx_occ != '0);
  assign data_out_i_in = r_tx_mem[r_tx_rp];
  assign tx_cnt        = r_tx_cnt;

  // --------------------------------------------------------------------------
  // RX handshake FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_CAP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_pop;
  logic   w_rx_enq;

  logic [pckg_sz-1:0] r_rx_mem [fifo_depth];
  logic [c_AW-1:0]    r_rx_wp;
  logic [c_AW-1:0]    r_rx_rp;
  logic [c_AW:0]      r_rx_occ;
  logic [15:0]        r_rx_cnt;
  logic [15:0]        r_misroute;
  logic               w_rx_deq;
  logic               w_rx_slot;
  logic               w_foreign;

  assign w_rx_deq  = rx_pop && (r_rx_occ != '0);
  // The IDLE decision reserves the slot for the capture two cycles later;
  // a host read in the decision cycle counts as freeing one.
  assign w_rx_slot = (r_rx_occ != c_DEPTH) || w_rx_deq;
  assign w_foreign = (data_out[pckg_sz-9:pckg_sz-16] != {c_ID_R, c_ID_C});

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rx_enq    = 1'b0;
    case (r_state)
      S_IDLE: if (pndng && w_rx_slot) w_state_nxt = S_POP;
      S_POP: begin
        w_pop       = 1'b1;
        w_state_nxt = S_CAP;
      end
      // The router registers its output on pop, so capture one cycle later.
      S_CAP: begin
        w_rx_enq    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_occ   <= '0;
      r_rx_cnt   <= '0;
      r_misroute <= '0;
    end else begin
      if (w_rx_enq) begin
        r_rx_wp  <= r_rx_wp + 1'b1;
        r_rx_cnt <= r_rx_cnt + 16'd1;
        if (w_foreign) r_misroute <= r_misroute + 16'd1;
      end
      if (w_rx_deq) r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_rx_enq, w_rx_deq})
        2'b10:   r_rx_occ <= r_rx_occ + c_ONE;
        2'b01:   r_rx_occ <= r_rx_occ - c_ONE;
        default: r_rx_occ <= r_rx_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_rx_enq) r_rx_mem[r_rx_wp] <= data_out;
  end

  assign pop      = w_pop;
  assign rx_valid = (r_rx_occ != '0);
  assign rx_data  = r_rx_mem[r_rx_rp];
  assign rx_cnt   = r_rx_cnt;
  assign misroute = r_misroute;

endmodule
`default_nettype wire

// File: doc/mesh_terminal_if.md
MESH_TERMINAL_IF -- requirements
Module: mesh_terminal_if

Interface
REQ-001 Parameter pckg_sz, default 40: packet width in bits.
REQ-002 Parameter fifo_depth, default 4: entries in each of the TX and RX queues (power of two, 2..16).
REQ-003 Parameter id_r, default 0: row coordinate of this terminal.
REQ-004 Parameter id_c, default 0: column coordinate of this terminal.
REQ-005 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- tx_push  in  1  host writes tx_data into the TX queue.
- tx_data  in  pckg_sz  host packet.
- tx_full  out  1  TX queue full.
- data_out_i_in  out  pckg_sz  head of the TX queue, toward the router.
- pndng_i_in  out  1  TX queue not empty.
- popin  in  1  router consumed data_out_i_in.
- data_out  in  pckg_sz  router output packet.
- pndng  in  1  router has a packet for this terminal.
- pop  out  1  terminal requests the router's next packet.
- rx_pop  in  1  host reads rx_data.
- rx_data  out  pckg_sz  head of the RX queue.
- rx_valid  out  1  RX queue not empty.
- tx_cnt  out  16  packets accepted by the router.
- rx_cnt  out  16  packets captured into the RX queue.
- misroute  out  16  captured packets whose destination is not (id_r, id_c).

Function
REQ-006 Packet fields SHALL be: [pckg_sz-1:pckg_sz-8] next-hop field; [pckg_sz-9:pckg_sz-12] destination row; [pckg_sz-13:pckg_sz-16] destination column; remaining bits are payload.
REQ-007 The TX side SHALL replace the next-hop field with 8'h00 on enqueue, and SHALL store all other bits unchanged.
REQ-008 The TX queue SHALL be a circular FIFO with wrap-around read/write pointers and an occupancy count of width $clog2(fifo_depth)+1.
REQ-009 data_out_i_in SHALL combinationally show the TX head; pndng_i_in SHALL be 1 exactly when TX occupancy > 0.
REQ-010 popin in a cycle with pndng_i_in=1 SHALL dequeue the TX head and increment tx_cnt; popin while the queue is empty SHALL be ignored.
REQ-011 tx_push while tx_full=1 SHALL be dropped with no state change, unless popin dequeues in the same cycle, in which case the push SHALL be accepted.
REQ-012 Simultaneous tx_push and popin on a non-empty queue SHALL leave occupancy unchanged.
REQ-013 The RX FSM SHALL have three states: IDLE, POP, CAP.
- IDLE->POP when pndng=1 and RX occupancy + 0 < fifo_depth (a free slot exists).
- POP->CAP unconditionally.
- CAP->IDLE unconditionally.
REQ-014 pop SHALL be 1 only in state POP, giving exactly one pop pulse per packet.
REQ-015 In CAP, the block SHALL enqueue data_out into the RX queue, i.e. one cycle after the pop pulse, because the router registers data_out on pop; it SHALL also increment rx_cnt.
REQ-016 In CAP, if data_out's destination row/column differs from (id_r, id_c), the block SHALL increment misroute and SHALL still enqueue the packet.
REQ-017 The minimum spacing between consecutive pop pulses SHALL be 3 cycles.
REQ-018 The IDLE->POP decision SHALL count a host rx_pop in the same cycle as freeing a slot.
REQ-019 rx_data/rx_valid SHALL show the RX head combinationally; rx_pop while rx_valid=0 SHALL be ignored.
REQ-020 A CAP enqueue and an rx_pop in the same cycle SHALL leave RX occupancy unchanged.
REQ-021 All counters SHALL wrap modulo 2^16.

Reset
REQ-022 When rst=0 at a clock edge, the block SHALL clear both queue pointers and occupancies, set the FSM to IDLE, and zero tx_cnt, rx_cnt and misroute; pop, pndng_i_in and rx_valid SHALL read 0, and tx_full SHALL read 0.
REQ-023 Reset asserted while the FSM is in POP or CAP SHALL abandon that packet; it SHALL NOT be enqueued and rx_cnt SHALL NOT increment.
REQ-024 Inputs SHALL be ignored in any cycle where rst=0.

Verification
REQ-025 TX path: with pckg_sz=40, push 40'hFF_12_345678 -> data_out_i_in=40'h00_12_345678 and pndng_i_in=1 next cycle; popin -> pndng_i_in=0 and tx_cnt=1.
REQ-026 TX full: with fifo_depth=4, do 5 pushes with no popin -> tx_full=1 and the 5th packet is lost; push+popin while full -> occupancy stays 4, and the new packet becomes the last to leave.
REQ-027 RX handshake: with (id_r,id_c)=(1,2), hold pndng=1 and data_out=40'h00_12_00AAAA -> one pop pulse, rx_valid=1 one cycle after CAP, rx_data=40'h00_12_00AAAA, rx_cnt=1, misroute=0.
REQ-028 RX backpressure: with pndng held 1 and no rx_pop -> exactly 4 pop pulses, each 3 cycles apart, then pop stays 0; one rx_pop -> exactly one more pop pulse.
REQ-029 Misroute: a captured packet with destination (3,0) at terminal (1,2) -> misroute=1, and the packet is present in the RX queue.
REQ-030 Reset mid-operation: drive rst=0 in the CAP cycle -> RX empty, rx_cnt=0, FSM in IDLE, pop=0 the next cycle.
